// File: rtl/seq_stream_checker.sv
// seq_stream_checker: receive-side self-check for an incrementing addr/data
// stream. Hunts for the +1 sequence, declares lock after LOCK_CNT consecutive
// in-sequence words, then counts good words and sequence errors and captures
// the first failing pair.
//
// Optional feature: define SEQ_CHK_TIMEOUT_EN to build an idle watchdog that
// drops lock after TIMEOUT_CYC consecutive idle cycles in LOCKED and raises
// the sticky timeout flag. Without it, timeout is tied low and LOCKED holds.
//
// Stream handshake: valid-only, no back-pressure. A word is consumed on every
// rising clk edge where in_valid=1; in_addr/in_data are don't-care otherwise.
// All outputs are registered and reflect a sample one cycle after it is taken.
//
// dbg_state exposes the FSM state (0=HUNT, 1=SYNC, 2=LOCKED) for checkers.

module seq_stream_checker #(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 32,
    parameter int LOCK_CNT    = 4,
    parameter int CNT_WIDTH   = 16,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic                  clk,
    input  logic                  sys_rst,
    input  logic                  clr,
    input  logic                  in_valid,
    input  logic [ADDR_WIDTH-1:0] in_addr,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  locked,
    output logic                  err_flag,
    output logic [CNT_WIDTH-1:0]  err_cnt,
    output logic [CNT_WIDTH-1:0]  word_cnt,
    output logic [ADDR_WIDTH-1:0] first_err_addr,
    output logic [DATA_WIDTH-1:0] first_err_data,
    output logic                  timeout,
    output logic [1:0]            dbg_state
);

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        SYNC   = 2'd1,
        LOCKED = 2'd2
    } state_t;

    localparam int RUN_W = $clog2(LOCK_CNT + 1);
    localparam logic [RUN_W-1:0]     RUN_ONE  = RUN_W'(1);
    localparam logic [RUN_W-1:0]     LOCK_RUN = RUN_W'(LOCK_CNT);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX  = '1;

    // Reject parameter values the lock/timeout logic cannot honour.
    if (LOCK_CNT < 2 || TIMEOUT_CYC < 1) begin : g_bad_params
        $error("seq_stream_checker: LOCK_CNT must be >= 2 and TIMEOUT_CYC >= 1");
    end

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] exp_addr_q, exp_addr_d;
    logic [DATA_WIDTH-1:0] exp_data_q, exp_data_d;
    logic [RUN_W-1:0]      run_q, run_d;
    logic                  locked_q, locked_d;
    logic                  err_flag_q, err_flag_d;
    logic [CNT_WIDTH-1:0]  err_cnt_q, err_cnt_d;
    logic [CNT_WIDTH-1:0]  word_cnt_q, word_cnt_d;
    logic [ADDR_WIDTH-1:0] first_err_addr_q, first_err_addr_d;
    logic [DATA_WIDTH-1:0] first_err_data_q, first_err_data_d;

`ifdef SEQ_CHK_TIMEOUT_EN
    localparam int IDLE_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT_CYC - 1);
    logic [IDLE_W-1:0]     idle_q, idle_d;
    logic                  timeout_q, timeout_d;
`endif

    logic                  in_match;
    logic                  src_restart;
    logic [RUN_W-1:0]      run_inc;

    // Match is checked before the 0/0 restart rule, so a wrapped 0/0
    // expectation is a good word rather than a source restart.
    always_comb begin
        in_match    = (in_addr == exp_addr_q) && (in_data == exp_data_q);
        src_restart = (in_addr == '0) && (in_data == '0);
        run_inc     = run_q + RUN_ONE;
    end

    // Next-state, expectation and counter update.
    always_comb begin
        state_d          = state_q;
        exp_addr_d       = exp_addr_q;
        exp_data_d       = exp_data_q;
        run_d            = run_q;
        locked_d         = locked_q;
        err_flag_d       = err_flag_q;
        err_cnt_d        = err_cnt_q;
        word_cnt_d       = word_cnt_q;
        first_err_addr_d = first_err_addr_q;
        first_err_data_d = first_err_data_q;
`ifdef SEQ_CHK_TIMEOUT_EN
        idle_d           = '0;
        timeout_d        = timeout_q;
`endif

        if (clr) begin
            // Clear wins over a sample taken in the same cycle.
            state_d          = HUNT;
            exp_addr_d       = '0;
            exp_data_d       = '0;
            run_d            = '0;
            locked_d         = 1'b0;
            err_flag_d       = 1'b0;
            err_cnt_d        = '0;
            word_cnt_d       = '0;
            first_err_addr_d = '0;
            first_err_data_d = '0;
`ifdef SEQ_CHK_TIMEOUT_EN
            timeout_d        = 1'b0;
`endif
        end else if (in_valid) begin
            case (state_q)
                HUNT: begin
                    exp_addr_d = in_addr + ADDR_WIDTH'(1);
                    exp_data_d = in_data + DATA_WIDTH'(1);
                    run_d      = RUN_ONE;
                    state_d    = SYNC;
                end
                SYNC: begin
                    if (in_match) begin
                        exp_addr_d = exp_addr_q + ADDR_WIDTH'(1);
                        exp_data_d = exp_data_q + DATA_WIDTH'(1);
                        run_d      = run_inc;
                        if (run_inc == LOCK_RUN) begin
                            state_d  = LOCKED;
                            locked_d = 1'b1;
                        end
                    end else begin
                        // Not locked yet: just restart the run from this word.
                        exp_addr_d = in_addr + ADDR_WIDTH'(1);
                        exp_data_d = in_data + DATA_WIDTH'(1);
                        run_d      = RUN_ONE;
                    end
                end
                LOCKED: begin
                    if (in_match) begin
                        word_cnt_d = word_cnt_q + CNT_WIDTH'(1);
                        exp_addr_d = exp_addr_q + ADDR_WIDTH'(1);
                        exp_data_d = exp_data_q + DATA_WIDTH'(1);
                    end else if (src_restart) begin
                        // Source restarted its sequence: resync, not an error.
                        state_d    = SYNC;
                        locked_d   = 1'b0;
                        run_d      = RUN_ONE;
                        exp_addr_d = ADDR_WIDTH'(1);
                        exp_data_d = DATA_WIDTH'(1);
                    end else begin
                        err_flag_d = 1'b1;
                        if (err_cnt_q != CNT_MAX) begin
                            err_cnt_d = err_cnt_q + CNT_WIDTH'(1);
                        end
                        if (err_cnt_q == '0) begin
                            first_err_addr_d = in_addr;
                            first_err_data_d = in_data;
                        end
                        // Follow the stream from the failing word onward.
                        exp_addr_d = in_addr + ADDR_WIDTH'(1);
                        exp_data_d = in_data + DATA_WIDTH'(1);
                    end
                end
                default: begin
                    state_d = HUNT;
                end
            endcase
        end
`ifdef SEQ_CHK_TIMEOUT_EN
        else if (state_q == LOCKED) begin
            // Idle while locked: drop lock on the TIMEOUT_CYC-th idle cycle.
            if (idle_q == IDLE_LAST) begin
                timeout_d = 1'b1;
                locked_d  = 1'b0;
                state_d   = HUNT;
            end else begin
                idle_d = idle_q + IDLE_W'(1);
            end
        end
`endif
    end

    // State and output registers.
    always_ff @(posedge clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q          <= HUNT;
            exp_addr_q       <= '0;
            exp_data_q       <= '0;
            run_q            <= '0;
            locked_q         <= 1'b0;
            err_flag_q       <= 1'b0;
            err_cnt_q        <= '0;
            word_cnt_q       <= '0;
            first_err_addr_q <= '0;
            first_err_data_q <= '0;
        end else begin
            state_q          <= state_d;
            exp_addr_q       <= exp_addr_d;
            exp_data_q       <= exp_data_d;
            run_q            <= run_d;
            locked_q         <= locked_d;
            err_flag_q       <= err_flag_d;
            err_cnt_q        <= err_cnt_d;
            word_cnt_q       <= word_cnt_d;
            first_err_addr_q <= first_err_addr_d;
            first_err_data_q <= first_err_data_d;
        end
    end

`ifdef SEQ_CHK_TIMEOUT_EN
    // Idle watchdog registers.
    always_ff @(posedge clk or posedge sys_rst) begin
        if (sys_rst) begin
            idle_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            idle_q    <= idle_d;
            timeout_q <= timeout_d;
        end
    end

    assign timeout = timeout_q;
`else
    assign timeout = 1'b0;
`endif

    assign locked         = locked_q;
    assign err_flag       = err_flag_q;
    assign err_cnt        = err_cnt_q;
    assign word_cnt       = word_cnt_q;
    assign first_err_addr = first_err_addr_q;
    assign first_err_data = first_err_data_q;
    assign dbg_state      = state_q;

endmodule
